// File: rtl/sseg_to_bcd_capture.sv
// Captures a multiplexed active-low 7-segment bus and rebuilds complete BCD frames.
// A digit is accepted once its {an,sseg} pattern has been stable for STABLE enabled samples.
module sseg_to_bcd_capture #(
   parameter int N_DIG  = 4,
   parameter int STABLE = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sample_en,
   input  logic [N_DIG-1:0]     an,
   input  logic [7:0]           sseg,
   output logic [4*N_DIG-1:0]   bcd_out,
   output logic [N_DIG-1:0]     dp_out,
   output logic [N_DIG-1:0]     err_out,
   output logic                 frame_valid,
   output logic                 sync_err
);

   localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   typedef enum logic {SYNC, COLLECT} state_t;

   state_t               state, state_next;
   logic [3:0]           cnt, cnt_next;
   logic                 accepted, accepted_next, accept;
   logic [N_DIG+7:0]     prev, sample;
   logic [N_DIG-1:0]     seen, seen_next, sel;
   logic                 one_low;
   logic [IDX_W-1:0]     idx;
   logic [3:0]           dec_bcd;
   logic                 dec_err;
   logic                 write_digit, complete, sync_err_next;
   logic [4*N_DIG-1:0]   shadow_bcd, shadow_bcd_next;
   logic [N_DIG-1:0]     shadow_dp, shadow_dp_next;
   logic [N_DIG-1:0]     shadow_err, shadow_err_next;

   always_comb begin
      dec_err = 1'b0;
      case (sseg[6:0])
         7'b0000001: dec_bcd = 4'd0;
         7'b1001111: dec_bcd = 4'd1;
         7'b0010010: dec_bcd = 4'd2;
         7'b0000110: dec_bcd = 4'd3;
         7'b1001100: dec_bcd = 4'd4;
         7'b0100100: dec_bcd = 4'd5;
         7'b0100000: dec_bcd = 4'd6;
         7'b0001111: dec_bcd = 4'd7;
         7'b0000000: dec_bcd = 4'd8;
         7'b0000100: dec_bcd = 4'd9;
         default: begin
            dec_bcd = 4'hF;
            dec_err = 1'b1;
         end
      endcase
   end

   // Digit index comes from the single low anode; anything else is a blank or overlap.
   always_comb begin
      sel     = ~an;
      one_low = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
      idx     = '0;
      for (int i = 0; i < N_DIG; i++) begin
         if (sel[i]) idx = IDX_W'(i);
      end
   end

   always_comb begin
      sample        = {an, sseg};
      cnt_next      = cnt;
      accepted_next = accepted;
      accept        = 1'b0;
      if (!one_low) begin
         cnt_next      = 4'd0;
         accepted_next = 1'b0;
      end else begin
         if (sample == prev) begin
            cnt_next = (cnt == 4'd15) ? cnt : cnt + 4'd1;
         end else begin
            cnt_next      = 4'd1;
            accepted_next = 1'b0;
         end
         if (cnt_next == 4'(STABLE) && !accepted_next) begin
            accept        = 1'b1;
            accepted_next = 1'b1;
         end
      end
   end

   // A repeated digit before completion drops the partial frame and is re-examined as a fresh start.
   always_comb begin
      state_next    = state;
      seen_next     = seen;
      write_digit   = 1'b0;
      complete      = 1'b0;
      sync_err_next = 1'b0;
      if (sample_en && accept) begin
         case (state)
            SYNC: begin
               if (idx == '0) begin
                  write_digit = 1'b1;
                  seen_next   = N_DIG'(1);
                  state_next  = COLLECT;
               end
            end
            COLLECT: begin
               if (!seen[idx]) begin
                  write_digit = 1'b1;
                  seen_next   = seen | sel;
                  if (&seen_next) begin
                     complete   = 1'b1;
                     seen_next  = '0;
                     state_next = SYNC;
                  end
               end else begin
                  sync_err_next = 1'b1;
                  if (idx == '0) begin
                     write_digit = 1'b1;
                     seen_next   = N_DIG'(1);
                     state_next  = COLLECT;
                  end else begin
                     seen_next  = '0;
                     state_next = SYNC;
                  end
               end
            end
            default: state_next = SYNC;
         endcase
      end
   end

   always_comb begin
      shadow_bcd_next = shadow_bcd;
      shadow_dp_next  = shadow_dp;
      shadow_err_next = shadow_err;
      shadow_bcd_next[int'(idx)*4 +: 4] = dec_bcd;
      shadow_dp_next[idx]  = ~sseg[7];
      shadow_err_next[idx] = dec_err;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= SYNC;
      else if (sample_en) state <= state_next;
   end

   // Outputs are loaded from the next-shadow view so the completing digit lands in the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= 4'd0;
         accepted    <= 1'b0;
         prev        <= '0;
         seen        <= '0;
         shadow_bcd  <= '0;
         shadow_dp   <= '0;
         shadow_err  <= '0;
         bcd_out     <= '0;
         dp_out      <= '0;
         err_out     <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (sample_en) begin
            cnt         <= cnt_next;
            accepted    <= accepted_next;
            prev        <= sample;
            seen        <= seen_next;
            frame_valid <= complete;
            sync_err    <= sync_err_next;
            if (write_digit) begin
               shadow_bcd <= shadow_bcd_next;
               shadow_dp  <= shadow_dp_next;
               shadow_err <= shadow_err_next;
            end
            if (complete) begin
               bcd_out <= shadow_bcd_next;
               dp_out  <= shadow_dp_next;
               err_out <= shadow_err_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_sseg_to_bcd_capture.sv
// Bench for sseg_to_bcd_capture: drives a STABLE=4 and a STABLE=1 instance from the same bus
// and compares both against a frame-level reference model.
module tb_sseg_to_bcd_capture;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sample_en = 1'b0;
   logic [3:0]  an = 4'hF;
   logic [7:0]  sseg = 8'hFF;

   logic [15:0] bcd4, bcd1;
   logic [3:0]  dp4, dp1, err4, err1;
   logic        fv4, fv1, se4, se1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sseg_to_bcd_capture #(.N_DIG(4), .STABLE(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .an(an), .sseg(sseg),
      .bcd_out(bcd4), .dp_out(dp4), .err_out(err4), .frame_valid(fv4), .sync_err(se4));

   sseg_to_bcd_capture #(.N_DIG(4), .STABLE(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .an(an), .sseg(sseg),
      .bcd_out(bcd1), .dp_out(dp1), .err_out(err1), .frame_valid(fv1), .sync_err(se1));

   // Reference model state, index 0 = STABLE 4 instance, index 1 = STABLE 1 instance.
   logic [6:0]  pat [10];
   int          stab [2];
   int          run [2];
   bit          acc [2];
   logic [11:0] prev [2];
   bit          in_frame [2];
   bit          got [2][4];
   logic [3:0]  sh_bcd [2][4];
   bit          sh_dp [2][4];
   bit          sh_err [2][4];
   logic [15:0] e_bcd [2];
   logic [3:0]  e_dp [2];
   logic [3:0]  e_err [2];
   bit          e_fv [2];
   bit          e_se [2];
   int          fv_cnt [2];
   int          se_cnt [2];
   int          pulse_mis [2];

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         run[m] = 0; acc[m] = 0; prev[m] = '0; in_frame[m] = 0;
         e_bcd[m] = '0; e_dp[m] = '0; e_err[m] = '0; e_fv[m] = 0; e_se[m] = 0;
         for (int d = 0; d < 4; d++) begin
            got[m][d] = 0; sh_bcd[m][d] = '0; sh_dp[m][d] = 0; sh_err[m][d] = 0;
         end
      end
   endtask

   task automatic store_digit(input int m, input int d);
      int v;
      v = -1;
      for (int k = 0; k < 10; k++) if (pat[k] == sseg[6:0]) v = k;
      got[m][d]    = 1;
      sh_bcd[m][d] = (v < 0) ? 4'hF : 4'(v);
      sh_err[m][d] = (v < 0);
      sh_dp[m][d]  = ~sseg[7];
   endtask

   task automatic model_accept(input int m, input int d);
      bit full;
      if (in_frame[m] && got[m][d]) begin
         e_se[m] = 1;
         in_frame[m] = 0;
         for (int k = 0; k < 4; k++) got[m][k] = 0;
      end
      if (!in_frame[m]) begin
         if (d == 0) begin
            in_frame[m] = 1;
            store_digit(m, 0);
         end
      end else begin
         store_digit(m, d);
         full = 1;
         for (int k = 0; k < 4; k++) if (!got[m][k]) full = 0;
         if (full) begin
            for (int k = 0; k < 4; k++) begin
               e_bcd[m][4*k +: 4] = sh_bcd[m][k];
               e_dp[m][k]  = sh_dp[m][k];
               e_err[m][k] = sh_err[m][k];
               got[m][k]   = 0;
            end
            in_frame[m] = 0;
            e_fv[m] = 1;
         end
      end
   endtask

   task automatic model_edge(input int m);
      int zeros, d;
      logic [11:0] key;
      e_fv[m] = 0;
      e_se[m] = 0;
      if (!sample_en) return;
      zeros = 0; d = 0;
      for (int k = 0; k < 4; k++) if (!an[k]) begin zeros++; d = k; end
      key = {an, sseg};
      if (zeros != 1) begin
         run[m] = 0; acc[m] = 0;
      end else if (key == prev[m]) begin
         if (run[m] < 15) run[m]++;
      end else begin
         run[m] = 1; acc[m] = 0;
      end
      prev[m] = key;
      if (zeros == 1 && run[m] == stab[m] && !acc[m]) begin
         acc[m] = 1;
         model_accept(m, d);
      end
   endtask

   // One clock: drive, let both DUTs and the model take the edge, then sample 1 time unit later.
   task automatic step(input logic [3:0] a, input logic [7:0] s, input bit en);
      an = a; sseg = s; sample_en = en;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      if (fv4 !== e_fv[0] || se4 !== e_se[0]) pulse_mis[0]++;
      if (fv1 !== e_fv[1] || se1 !== e_se[1]) pulse_mis[1]++;
      fv_cnt[0] += int'(fv4); fv_cnt[1] += int'(fv1);
      se_cnt[0] += int'(se4); se_cnt[1] += int'(se1);
   endtask

   task automatic show(input int d, input logic [7:0] s, input int hold);
      logic [3:0] a;
      a = 4'hF;
      a[d] = 1'b0;
      for (int k = 0; k < hold; k++) step(a, s, 1'b1);
   endtask

   function automatic logic [7:0] seg(input int v, input bit dp);
      return {~dp, pat[v]};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bcd4, dp4, err4, fv4, se4} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_s4 got %h required 0", {bcd4, dp4, err4, fv4, se4});
      end
      checks++;
      if ({bcd1, dp1, err1, fv1, se1} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_s1 got %h required 0", {bcd1, dp1, err1, fv1, se1});
      end
      reset_n = 1'b1;
   endtask

   task automatic test_clean_scan();
      int f0;
      f0 = fv_cnt[0];
      show(0, seg(7, 0), 4); show(1, seg(3, 0), 4);
      show(2, seg(0, 0), 4); show(3, seg(9, 0), 4);
      step(4'hF, 8'hFF, 1'b1);
      checks++;
      if (bcd4 !== 16'h9037 || err4 !== 4'h0 || dp4 !== 4'h0) begin
         errors++;
         $display("[TB] FAIL clean_scan got bcd=%h err=%b dp=%b required 9037/0000/0000", bcd4, err4, dp4);
      end
      checks++;
      if (fv_cnt[0] - f0 !== 1) begin
         errors++;
         $display("[TB] FAIL clean_scan_pulses got %0d required 1", fv_cnt[0] - f0);
      end
      checks++;
      if (bcd1 !== e_bcd[1] || pulse_mis[1] !== 0) begin
         errors++;
         $display("[TB] FAIL clean_scan_s1 got %h/%0d required %h/0", bcd1, pulse_mis[1], e_bcd[1]);
      end
   endtask

   task automatic test_short_dwell();
      int f0;
      f0 = fv_cnt[0];
      show(0, seg(1, 0), 4); show(1, seg(2, 0), 3);
      show(2, seg(3, 0), 4); show(3, seg(4, 0), 4);
      checks++;
      if (fv_cnt[0] - f0 !== 0 || bcd4 !== 16'h9037) begin
         errors++;
         $display("[TB] FAIL short_dwell got pulses=%0d bcd=%h required 0/9037", fv_cnt[0] - f0, bcd4);
      end
      show(0, seg(5, 0), 4); show(1, seg(6, 0), 4);
      show(2, seg(8, 0), 4); show(3, seg(2, 0), 4);
      checks++;
      if (fv_cnt[0] - f0 !== 1 || bcd4 !== 16'h2865) begin
         errors++;
         $display("[TB] FAIL short_dwell_resync got pulses=%0d bcd=%h required 1/2865", fv_cnt[0] - f0, bcd4);
      end
   endtask

   task automatic test_bad_pattern();
      show(0, seg(4, 0), 4); show(1, seg(1, 1), 4);
      show(2, 8'hFF, 4);     show(3, seg(0, 0), 4);
      checks++;
      if (bcd4[11:8] !== 4'hF || err4 !== 4'b0100 || dp4 !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL bad_pattern got nib=%h err=%b dp=%b required F/0100/0010", bcd4[11:8], err4, dp4);
      end
      checks++;
      if (bcd4 !== e_bcd[0] || bcd1 !== e_bcd[1] || err1 !== e_err[1] || dp1 !== e_dp[1]) begin
         errors++;
         $display("[TB] FAIL bad_pattern_model got %h/%h required %h/%h", bcd4, bcd1, e_bcd[0], e_bcd[1]);
      end
   endtask

   task automatic test_sync_err();
      int f0, s0;
      f0 = fv_cnt[0]; s0 = se_cnt[0];
      show(0, seg(0, 0), 4); show(1, seg(1, 0), 4);
      step(4'hF, 8'hFF, 1'b1);
      show(1, seg(1, 0), 4); show(2, seg(2, 0), 4);
      checks++;
      if (se_cnt[0] - s0 !== 1 || fv_cnt[0] - f0 !== 0) begin
         errors++;
         $display("[TB] FAIL sync_err got se=%0d fv=%0d required 1/0", se_cnt[0] - s0, fv_cnt[0] - f0);
      end
      show(3, seg(3, 0), 4);
      checks++;
      if (fv_cnt[0] - f0 !== 0 || pulse_mis[0] !== 0) begin
         errors++;
         $display("[TB] FAIL sync_err_state got fv=%0d mis=%0d required 0/0", fv_cnt[0] - f0, pulse_mis[0]);
      end
   endtask

   task automatic test_blank_and_pause();
      repeat (10) step(4'b1100, seg(8, 0), 1'b1);
      repeat (10) step(4'b1111, seg(8, 0), 1'b1);
      checks++;
      if (dut4.cnt !== 4'd0 || se_cnt[0] + fv_cnt[0] < 0) begin
         errors++;
         $display("[TB] FAIL blank_cnt got %0d required 0", dut4.cnt);
      end
      show(0, seg(6, 0), 2);
      repeat (3) step(4'b1110, seg(6, 0), 1'b0);
      checks++;
      if (dut4.cnt !== 4'(run[0]) || run[0] != 2) begin
         errors++;
         $display("[TB] FAIL pause_cnt got %0d required 2", dut4.cnt);
      end
      show(0, seg(6, 0), 2); show(1, seg(7, 0), 4);
      show(2, seg(8, 0), 4); show(3, seg(9, 0), 4);
      checks++;
      if (bcd4 !== 16'h9876 || pulse_mis[0] !== 0) begin
         errors++;
         $display("[TB] FAIL pause_frame got %h/%0d required 9876/0", bcd4, pulse_mis[0]);
      end
   endtask

   task automatic test_reset_mid();
      int f0;
      show(0, seg(2, 0), 4); show(1, seg(3, 0), 4);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({bcd4, dp4, err4, bcd1, dp1, err1} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid got %h/%h required 0", bcd4, bcd1);
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      f0 = fv_cnt[0];
      show(2, seg(4, 0), 4); show(3, seg(5, 0), 4);
      checks++;
      if (fv_cnt[0] - f0 !== 0 || bcd4 !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid_partial got fv=%0d bcd=%h required 0/0", fv_cnt[0] - f0, bcd4);
      end
      show(0, seg(1, 0), 4); show(1, seg(2, 0), 4);
      show(2, seg(3, 0), 4); show(3, seg(4, 0), 4);
      checks++;
      if (fv_cnt[0] - f0 !== 1 || bcd4 !== 16'h4321) begin
         errors++;
         $display("[TB] FAIL reset_mid_frame got fv=%0d bcd=%h required 1/4321", fv_cnt[0] - f0, bcd4);
      end
   endtask

   task automatic test_stable1_scan();
      int f1;
      f1 = fv_cnt[1];
      step(4'hF, 8'hFF, 1'b1);
      step(4'b1110, seg(5, 1), 1'b1); step(4'b1101, seg(6, 0), 1'b1);
      step(4'b1011, seg(7, 0), 1'b1); step(4'b0111, seg(8, 1), 1'b1);
      checks++;
      if (fv_cnt[1] - f1 !== 1 || bcd1 !== 16'h8765 || dp1 !== 4'b1001) begin
         errors++;
         $display("[TB] FAIL stable1_scan got fv=%0d bcd=%h dp=%b required 1/8765/1001", fv_cnt[1] - f1, bcd1, dp1);
      end
   endtask

   task automatic test_random();
      int d, v, hold;
      logic [3:0] a;
      logic [7:0] s;
      d = 3;
      for (int n = 0; n < 300; n++) begin
         d = ($urandom_range(0, 9) < 7) ? (d + 1) % 4 : int'($urandom_range(0, 3));
         v = $urandom_range(0, 9);
         s = ($urandom_range(0, 9) == 0) ? 8'($urandom) : seg(v, 1'($urandom));
         a = 4'hF;
         a[d] = 1'b0;
         if ($urandom_range(0, 9) == 0) a = 4'($urandom);
         hold = $urandom_range(1, 6);
         for (int k = 0; k < hold; k++) step(a, s, $urandom_range(0, 99) < 85);
         if (n % 50 == 49) begin
            checks++;
            if (bcd4 !== e_bcd[0] || dp4 !== e_dp[0] || err4 !== e_err[0] ||
                bcd1 !== e_bcd[1] || dp1 !== e_dp[1] || err1 !== e_err[1]) begin
               errors++;
               $display("[TB] FAIL random_frame got %h %b %b / %h %b %b required %h %b %b / %h %b %b",
                        bcd4, dp4, err4, bcd1, dp1, err1, e_bcd[0], e_dp[0], e_err[0], e_bcd[1], e_dp[1], e_err[1]);
            end
         end
      end
      checks++;
      if (pulse_mis[0] !== 0 || pulse_mis[1] !== 0) begin
         errors++;
         $display("[TB] FAIL random_pulses got %0d/%0d mismatched cycles required 0/0", pulse_mis[0], pulse_mis[1]);
      end
   endtask

   initial begin
      pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
      stab = '{4, 1};
      fv_cnt = '{0, 0}; se_cnt = '{0, 0}; pulse_mis = '{0, 0};
      model_reset();
      test_reset();
      test_clean_scan();
      test_short_dwell();
      test_bad_pattern();
      test_sync_err();
      test_blank_and_pause();
      test_reset_mid();
      test_stable1_scan();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
